sint_ray_issue: RTL and testbench

- Producer and return end of the scene-intersection interface: issues rays to scene_int over shader_to_sint and consumes its sint_to_shader miss returns.
- Tracks every outstanding rayID in a bitmap. Blocks reissue of a live ID.
- Caps in-flight rays to the scene_int pipe plus FIFO capacity, so scene_int buffers never overflow.
- Sits between the ray generator/shader dispatch and scene_int. Hits retire through a separate done strobe from the shader.

---
 rtl/sint_ray_issue_pkg.sv | 16 +
 rtl/sint_ray_issue_ray_id_tracker.sv | 59 +++++
 rtl/sint_ray_issue.sv | 78 +++++++
 tb/tb_sint_ray_issue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sint_ray_issue_pkg.sv
// sint_ray_issue_pkg: shared ray/return types and scene_int capacity
package sint_ray_issue_pkg;
    localparam int SINT_CAPACITY = 35;
    localparam int RAY_ID_W = 9;
    localparam int NUM_IDS = 1 << RAY_ID_W;
    typedef logic [RAY_ID_W-1:0] rayID_t;
    typedef struct packed {
        rayID_t ray_id;
        logic is_shadow;
        logic [47:0] origin;
        logic [47:0] dir;
    } shader_to_sint_t;
    typedef struct packed {
        rayID_t ray_id;
    } sint_to_shader_t;
endpackage

// File: rtl/sint_ray_issue_ray_id_tracker.sv
// sint_ray_issue_ray_id_tracker: live-rayID bitmap, outstanding counter and protocol-error detect
module sint_ray_issue_ray_id_tracker
    import sint_ray_issue_pkg::*;
#(
    parameter int MAX_OUT = SINT_CAPACITY,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_valid,
    input  rayID_t           set_id,
    input  logic             clr_a_valid,
    input  rayID_t           clr_a_id,
    input  logic             clr_b_valid,
    input  rayID_t           clr_b_id,
    input  rayID_t           lookup_id,
    output logic             lookup_free,
    output logic             room,
    output logic [CNT_W-1:0] count,
    output logic             err
);
    logic [NUM_IDS-1:0] live_q, live_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic err_q, same_id, a_ok, b_ok, bad_clr, underflow;
    logic [1:0] dec;

    // Effective clears (a duplicate ID retires once), set-wins bitmap update and net count
    always_comb begin
        same_id = clr_a_valid && clr_b_valid && (clr_a_id == clr_b_id);
        a_ok = clr_a_valid && live_q[clr_a_id];
        b_ok = clr_b_valid && live_q[clr_b_id] && !same_id;
        bad_clr = (clr_a_valid && !live_q[clr_a_id]) || (clr_b_valid && !live_q[clr_b_id]);
        dec = {1'b0, a_ok} + {1'b0, b_ok};
        underflow = (count_q + CNT_W'(set_valid)) < CNT_W'(dec);
        live_d = live_q;
        if (a_ok) live_d[clr_a_id] = 1'b0;
        if (b_ok) live_d[clr_b_id] = 1'b0;
        if (set_valid) live_d[set_id] = 1'b1;
        count_d = count_q + CNT_W'(set_valid) - (underflow ? CNT_W'(0) : CNT_W'(dec));
        lookup_free = !live_q[lookup_id] || (a_ok && clr_a_id == lookup_id) || (b_ok && clr_b_id == lookup_id);
        room = (count_q < CNT_W'(MAX_OUT)) || (dec != 2'd0);
    end

    // Bitmap, counter and sticky error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
            count_q <= '0;
            err_q <= 1'b0;
        end else begin
            live_q <= live_d;
            count_q <= count_d;
            err_q <= err_q || same_id || bad_clr || underflow;
        end
    end

    assign count = count_q;
    assign err = err_q;
endmodule

// File: rtl/sint_ray_issue.sv
// sint_ray_issue: issues rays to scene_int with live-ID and in-flight limits, forwards miss returns
module sint_ray_issue
    import sint_ray_issue_pkg::*;
#(
    parameter int MAX_OUT = SINT_CAPACITY,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_valid,
    input  shader_to_sint_t  gen_data,
    output logic             gen_stall,
    output logic             shader_to_sint_valid,
    output shader_to_sint_t  shader_to_sint_data,
    input  logic             shader_to_sint_stall,
    input  logic             sint_to_shader_valid,
    input  sint_to_shader_t  sint_to_shader_data,
    output logic             sint_to_shader_stall,
    output logic             miss_valid,
    output rayID_t           miss_rayID,
    input  logic             miss_stall,
    input  logic             done_valid,
    input  rayID_t           done_rayID,
    output logic [CNT_W-1:0] num_outstanding,
    output logic             idle,
    output logic             err
);
    logic iss_open, miss_open, gen_accept, miss_accept, lookup_free, room;

    assign iss_open = !shader_to_sint_valid || !shader_to_sint_stall;
    assign gen_accept = gen_valid && iss_open && lookup_free && room;
    assign gen_stall = gen_valid && !gen_accept;
    assign miss_open = !miss_valid || !miss_stall;
    assign miss_accept = sint_to_shader_valid && miss_open;
    assign sint_to_shader_stall = miss_valid && miss_stall;
    assign idle = (num_outstanding == '0) && !shader_to_sint_valid && !miss_valid;

    sint_ray_issue_ray_id_tracker #(
        .MAX_OUT(MAX_OUT),
        .CNT_W(CNT_W)
    ) u_ray_id_tracker (
        .clk(clk),
        .rst(rst),
        .set_valid(gen_accept),
        .set_id(gen_data.ray_id),
        .clr_a_valid(miss_accept),
        .clr_a_id(sint_to_shader_data.ray_id),
        .clr_b_valid(done_valid),
        .clr_b_id(done_rayID),
        .lookup_id(gen_data.ray_id),
        .lookup_free(lookup_free),
        .room(room),
        .count(num_outstanding),
        .err(err)
    );

    // One-entry issue register toward scene_int; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shader_to_sint_valid <= 1'b0;
            shader_to_sint_data <= '0;
        end else if (iss_open) begin
            shader_to_sint_valid <= gen_accept;
            if (gen_accept) shader_to_sint_data <= gen_data;
        end
    end

    // One-entry miss register toward the shader; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_valid <= 1'b0;
            miss_rayID <= '0;
        end else if (miss_open) begin
            miss_valid <= miss_accept;
            if (miss_accept) miss_rayID <= sint_to_shader_data.ray_id;
        end
    end
endmodule

// File: tb/tb_sint_ray_issue.sv
// tb_sint_ray_issue: table-driven and directed-sequence checks for sint_ray_issue
module tb_sint_ray_issue;
    import sint_ray_issue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gen_valid = 1'b0;
    shader_to_sint_t gen_data = '0;
    logic gen_stall;
    logic shader_to_sint_valid;
    shader_to_sint_t shader_to_sint_data;
    logic shader_to_sint_stall = 1'b0;
    logic sint_to_shader_valid = 1'b0;
    sint_to_shader_t sint_to_shader_data = '0;
    logic sint_to_shader_stall;
    logic miss_valid;
    rayID_t miss_rayID;
    logic miss_stall = 1'b0;
    logic done_valid = 1'b0;
    rayID_t done_rayID = '0;
    logic [9:0] num_outstanding;
    logic idle;
    logic err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sint_ray_issue dut (
        .clk(clk),
        .rst(rst),
        .gen_valid(gen_valid),
        .gen_data(gen_data),
        .gen_stall(gen_stall),
        .shader_to_sint_valid(shader_to_sint_valid),
        .shader_to_sint_data(shader_to_sint_data),
        .shader_to_sint_stall(shader_to_sint_stall),
        .sint_to_shader_valid(sint_to_shader_valid),
        .sint_to_shader_data(sint_to_shader_data),
        .sint_to_shader_stall(sint_to_shader_stall),
        .miss_valid(miss_valid),
        .miss_rayID(miss_rayID),
        .miss_stall(miss_stall),
        .done_valid(done_valid),
        .done_rayID(done_rayID),
        .num_outstanding(num_outstanding),
        .idle(idle),
        .err(err)
    );

    typedef struct {
        logic gv; logic [8:0] gid; logic ss;
        logic sv; logic [8:0] sid; logic ms;
        logic dv; logic [8:0] did;
        logic e_gst; logic e_sst;
        logic e_ov; logic [8:0] e_oid;
        logic e_mv; logic [8:0] e_mid;
        int e_cnt; logic e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic shader_to_sint_t mkray(input logic [8:0] id);
        shader_to_sint_t r;
        r.ray_id = id;
        r.is_shadow = id[0];
        r.origin = 48'h1234_5678_9abc + 48'(id);
        r.dir = ~r.origin;
        return r;
    endfunction

    function automatic vec_t mk(input logic gv, input int gid, input logic ss, input logic sv, input int sid,
                                input logic ms, input logic dv, input int did, input logic e_gst, input logic e_sst,
                                input logic e_ov, input int e_oid, input logic e_mv, input int e_mid,
                                input int e_cnt, input logic e_err);
        vec_t v;
        v.gv = gv; v.gid = 9'(gid); v.ss = ss; v.sv = sv; v.sid = 9'(sid); v.ms = ms;
        v.dv = dv; v.did = 9'(did); v.e_gst = e_gst; v.e_sst = e_sst; v.e_ov = e_ov;
        v.e_oid = 9'(e_oid); v.e_mv = e_mv; v.e_mid = 9'(e_mid); v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic gv, input int gid, input logic ss, input logic sv, input int sid,
                         input logic ms, input logic dv, input int did);
        gen_valid = gv;
        gen_data = mkray(9'(gid));
        shader_to_sint_stall = ss;
        sint_to_shader_valid = sv;
        sint_to_shader_data = '{ray_id: 9'(sid)};
        miss_stall = ms;
        done_valid = dv;
        done_rayID = 9'(did);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.gv, int'(v.gid), v.ss, v.sv, int'(v.sid), v.ms, v.dv, int'(v.did));
        #1;
        chk($sformatf("v%0d gen_stall", idx), 128'(gen_stall), 128'(v.e_gst));
        chk($sformatf("v%0d sint_to_shader_stall", idx), 128'(sint_to_shader_stall), 128'(v.e_sst));
        tick();
        chk($sformatf("v%0d shader_to_sint_valid", idx), 128'(shader_to_sint_valid), 128'(v.e_ov));
        if (v.e_ov) chk($sformatf("v%0d shader_to_sint_data", idx), 128'(shader_to_sint_data), 128'(mkray(v.e_oid)));
        chk($sformatf("v%0d miss_valid", idx), 128'(miss_valid), 128'(v.e_mv));
        if (v.e_mv) chk($sformatf("v%0d miss_rayID", idx), 128'(miss_rayID), 128'(v.e_mid));
        chk($sformatf("v%0d num_outstanding", idx), 128'(num_outstanding), 128'(v.e_cnt));
        chk($sformatf("v%0d err", idx), 128'(err), 128'(v.e_err));
    endtask

    initial begin
        //             gv gid ss sv sid ms dv did | gst sst ov oid mv mid cnt err
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2, 0, 0, 3, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0,   0, 0, 1, 3, 0, 0, 4, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0,   0, 0, 1, 4, 0, 0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 5, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0,   0, 0, 1, 7, 0, 0, 6, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(1, 7, 0, 1, 7, 0, 0, 0,   0, 0, 1, 7, 1, 7, 6, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5, 0, 0, 7, 0));
        tbl.push_back(mk(1, 9, 0, 1, 3, 0, 1, 5,   0, 0, 1, 9, 1, 3, 6, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0,   0, 0, 1, 3, 0, 0, 7, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5, 0, 0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0,   0, 1, 0, 0, 1, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1, 6, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 6, 0));

        do_reset();
        chk("reset idle", 128'(idle), 128'(1));
        chk("reset num_outstanding", 128'(num_outstanding), 128'(0));
        chk("reset shader_to_sint_valid", 128'(shader_to_sint_valid), 128'(0));
        chk("reset shader_to_sint_data", 128'(shader_to_sint_data), 128'(0));
        chk("reset miss_valid", 128'(miss_valid), 128'(0));
        chk("reset err", 128'(err), 128'(0));

        foreach (tbl[i]) apply(tbl[i], i);

        // In-flight cap: 35 distinct IDs fill it, a done releases the 36th in the same cycle
        do_reset();
        for (int i = 0; i < 35; i++) begin
            drive(1, 100 + i, 0, 0, 0, 0, 0, 0);
            #1 chk($sformatf("cap issue %0d gen_stall", i), 128'(gen_stall), 128'(0));
            tick();
        end
        chk("cap count", 128'(num_outstanding), 128'(35));
        drive(1, 135, 0, 0, 0, 0, 0, 0);
        #1 chk("cap 36th gen_stall", 128'(gen_stall), 128'(1));
        tick();
        chk("cap hold count", 128'(num_outstanding), 128'(35));
        chk("cap hold valid", 128'(shader_to_sint_valid), 128'(0));
        drive(1, 135, 0, 0, 0, 0, 1, 110);
        #1 chk("cap release gen_stall", 128'(gen_stall), 128'(0));
        tick();
        chk("cap release count", 128'(num_outstanding), 128'(35));
        chk("cap release valid", 128'(shader_to_sint_valid), 128'(1));
        chk("cap release data", 128'(shader_to_sint_data), 128'(mkray(9'd135)));
        chk("cap err", 128'(err), 128'(0));

        // Downstream stall holds the issue register; then one ray per cycle drains
        do_reset();
        drive(1, 200, 0, 0, 0, 0, 0, 0);
        tick();
        chk("stall first data", 128'(shader_to_sint_data), 128'(mkray(9'd200)));
        for (int k = 0; k < 3; k++) begin
            drive(1, 201, 1, 0, 0, 0, 0, 0);
            #1 chk($sformatf("stall %0d gen_stall", k), 128'(gen_stall), 128'(1));
            tick();
            chk($sformatf("stall %0d valid", k), 128'(shader_to_sint_valid), 128'(1));
            chk($sformatf("stall %0d data", k), 128'(shader_to_sint_data), 128'(mkray(9'd200)));
            chk($sformatf("stall %0d count", k), 128'(num_outstanding), 128'(1));
        end
        drive(1, 201, 0, 0, 0, 0, 0, 0);
        #1 chk("release gen_stall", 128'(gen_stall), 128'(0));
        tick();
        chk("release data 201", 128'(shader_to_sint_data), 128'(mkray(9'd201)));
        drive(1, 202, 0, 0, 0, 0, 0, 0);
        tick();
        chk("release data 202", 128'(shader_to_sint_data), 128'(mkray(9'd202)));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("release drained", 128'(shader_to_sint_valid), 128'(0));
        chk("release count", 128'(num_outstanding), 128'(3));

        // Error: done for a non-live ID
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 12);
        tick();
        chk("done non-live err", 128'(err), 128'(1));
        chk("done non-live count", 128'(num_outstanding), 128'(0));

        // Error: miss and done on the same live ID in one cycle
        do_reset();
        chk("err cleared by reset", 128'(err), 128'(0));
        drive(1, 20, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 20, 0, 1, 20);
        tick();
        chk("dup clear err", 128'(err), 128'(1));
        chk("dup clear count", 128'(num_outstanding), 128'(0));
        chk("dup clear miss_rayID", 128'(miss_rayID), 128'(20));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("err sticky", 128'(err), 128'(1));

        // Asynchronous reset mid-traffic discards everything immediately
        drive(1, 30, 0, 1, 40, 0, 0, 0);
        tick();
        chk("pre-reset valid", 128'(shader_to_sint_valid), 128'(1));
        chk("pre-reset miss_valid", 128'(miss_valid), 128'(1));
        drive(1, 31, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", 128'(shader_to_sint_valid), 128'(0));
        chk("async rst data", 128'(shader_to_sint_data), 128'(0));
        chk("async rst miss_valid", 128'(miss_valid), 128'(0));
        chk("async rst count", 128'(num_outstanding), 128'(0));
        chk("async rst idle", 128'(idle), 128'(1));
        chk("async rst err", 128'(err), 128'(0));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
